memory_address_register: RTL and testbench

MEMORY_ADDRESS_REGISTER -- requirements
Module: memory_address_register

---
 rtl/memory_address_register.sv | 159 +++++++++++++++
 tb/tb_memory_address_register.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_address_register.sv
// Memory address register with manual programming front end.
// Run mode: a 4-bit MAR loads from the low nibble of the CPU bus.
// Manual mode: a debounced program-write button produces a one-cycle
// RAM write strobe (manual_read) for the address on the switches.
// Optional feature macro: MAR_AUTO_INCREMENT_EN. When it is defined, the
// manual address comes from a pointer that steps after each write.
module memory_address_register #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       read_from_bus,
    input  logic [7:0] bus,
    input  logic       manual_mode,
    input  logic [3:0] address_switches,
    input  logic       write_button,
    output logic [3:0] address,
    output logic       manual_read
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        FIRE,
        HELD
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [3:0] mar;
    logic [3:0] manual_addr;
    logic       btn_meta;
    logic       btn_s;
    logic       btn_prev;
    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;

    // Only the low nibble of the bus carries an address.
    logic [3:0] unused_bus_hi;
    assign unused_bus_hi = bus[7:4];

    // Run-mode MAR: loads from the bus only outside manual mode, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mar <= 4'd0;
        end else if (read_from_bus && !manual_mode) begin
            mar <= bus[3:0];
        end
    end

    // Two-flop synchroniser for the raw button, plus a delayed copy so a press
    // is only recognised on a fresh low-to-high transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_meta <= write_button;
            btn_s    <= btn_meta;
            btn_prev <= btn_s;
        end
    end

    // Debounce state and stability counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Debounce next-state logic; leaving manual mode aborts any press, and a
    // button still held afterwards must be released before it counts again.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!manual_mode) begin
            state_next = IDLE;
            cnt_next   = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = 8'd0;
                    if (btn_s && !btn_prev) begin
                        state_next = PRESS;
                    end
                end
                PRESS: begin
                    if (!btn_s) begin
                        state_next = IDLE;
                        cnt_next   = 8'd0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = FIRE;
                        cnt_next   = 8'd0;
                    end else begin
                        cnt_next = cnt + 8'd1;
                    end
                end
                FIRE: begin
                    state_next = HELD;
                    cnt_next   = 8'd0;
                end
                HELD: begin
                    if (btn_s) begin
                        cnt_next = 8'd0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = IDLE;
                        cnt_next   = 8'd0;
                    end else begin
                        cnt_next = cnt + 8'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end
            endcase
        end
    end

    assign manual_read = (state == FIRE) && manual_mode;

`ifdef MAR_AUTO_INCREMENT_EN
    logic [3:0] ptr;
    logic [3:0] switches_q;
    logic       mode_q;

    // Address pointer: reloads from the switches on entry to manual mode or on
    // any switch change, else steps after each write so RAM sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= 4'd0;
            switches_q <= 4'd0;
            mode_q     <= 1'b0;
        end else begin
            mode_q     <= manual_mode;
            switches_q <= address_switches;
            if ((manual_mode && !mode_q) || (address_switches != switches_q)) begin
                ptr <= address_switches;
            end else if (manual_read) begin
                ptr <= ptr + 4'd1;
            end
        end
    end

    assign manual_addr = ptr;
`else
    assign manual_addr = address_switches;
`endif

    assign address = manual_mode ? manual_addr : mar;

endmodule

// File: tb/tb_memory_address_register.sv
// Directed self-checking bench for memory_address_register (DEBOUNCE_CYCLES=4).
// Expectations cover both builds, with and without MAR_AUTO_INCREMENT_EN.
module tb_memory_address_register;

    logic       clk;
    logic       rst;
    logic       read_from_bus;
    logic [7:0] bus;
    logic       manual_mode;
    logic [3:0] address_switches;
    logic       write_button;
    logic [3:0] address;
    logic       manual_read;

    int         checks;
    int         errors;
    int         pulse_count;
    int         ticks;
    int         pulse_tick;
    int         start_tick;
    logic [3:0] pulse_addrs[$];

    memory_address_register #(.DEBOUNCE_CYCLES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .read_from_bus   (read_from_bus),
        .bus             (bus),
        .manual_mode     (manual_mode),
        .address_switches(address_switches),
        .write_button    (write_button),
        .address         (address),
        .manual_read     (manual_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the button for n cycles, recording every cycle with manual_read high.
    task automatic applyStimulus(input logic btn, input int n);
        for (int i = 0; i < n; i++) begin
            write_button = btn;
            @(posedge clk);
            #1;
            ticks++;
            if (manual_read === 1'b1) begin
                pulse_count++;
                pulse_tick = ticks;
                pulse_addrs.push_back(address);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        pulse_count      = 0;
        ticks            = 0;
        pulse_tick       = 0;
        start_tick       = 0;
        rst              = 1'b1;
        read_from_bus    = 1'b0;
        bus              = 8'h00;
        manual_mode      = 1'b0;
        address_switches = 4'h0;
        write_button     = 1'b0;

        // Reset state
        #2;
        checkOutput("reset_address", 8'(address), 8'h0);
        checkOutput("reset_manual_read", 8'(manual_read), 8'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Run-mode load from bus; upper nibble ignored
        bus = 8'hA7;
        read_from_bus = 1'b1;
        tick();
        read_from_bus = 1'b0;
        bus = 8'h3C;
        checkOutput("load_a7", 8'(address), 8'h7);
        tick();
        tick();
        checkOutput("hold_a7", 8'(address), 8'h7);
        bus = 8'hF2;
        read_from_bus = 1'b1;
        tick();
        read_from_bus = 1'b0;
        checkOutput("load_f2", 8'(address), 8'h2);

        // Manual address follows the switches; mar retained across mode change
        manual_mode = 1'b1;
        address_switches = 4'h3;
        #1;
`ifdef MAR_AUTO_INCREMENT_EN
        tick();
`endif
        checkOutput("manual_addr_3", 8'(address), 8'h3);
        address_switches = 4'hC;
        #1;
`ifdef MAR_AUTO_INCREMENT_EN
        tick();
`endif
        checkOutput("manual_addr_c", 8'(address), 8'hC);
        manual_mode = 1'b0;
        #1;
        checkOutput("mar_retained", 8'(address), 8'h2);
        tick();

        // Bouncing press then long hold: one pulse, 1 cycle, latency 2+4
        manual_mode = 1'b1;
        address_switches = 4'h5;
        applyStimulus(1'b0, 2);
        pulse_count = 0;
        pulse_addrs.delete();
        start_tick = ticks;
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 21);
        checkOutput("bounce_pulse_cycles", 8'(pulse_count), 8'd1);
        checkOutput("bounce_latency", 8'(pulse_tick - start_tick), 8'd9);
        if (pulse_addrs.size() > 0) begin
            checkOutput("bounce_pulse_addr", 8'(pulse_addrs[0]), 8'h5);
        end
        applyStimulus(1'b0, 12);
        checkOutput("release_no_pulse", 8'(pulse_count), 8'd1);
`ifdef MAR_AUTO_INCREMENT_EN
        checkOutput("ptr_after_write", 8'(address), 8'h6);
`else
        checkOutput("addr_after_write", 8'(address), 8'h5);
`endif

        // Three clean presses at switches E
        address_switches = 4'hE;
        applyStimulus(1'b0, 2);
        pulse_count = 0;
        pulse_addrs.delete();
        for (int p = 0; p < 3; p++) begin
            applyStimulus(1'b1, 10);
            applyStimulus(1'b0, 10);
        end
        checkOutput("three_presses", 8'(pulse_count), 8'd3);
        if (pulse_addrs.size() == 3) begin
`ifdef MAR_AUTO_INCREMENT_EN
            checkOutput("press1_addr", 8'(pulse_addrs[0]), 8'hE);
            checkOutput("press2_addr", 8'(pulse_addrs[1]), 8'hF);
            checkOutput("press3_addr", 8'(pulse_addrs[2]), 8'h0);
`else
            checkOutput("press1_addr", 8'(pulse_addrs[0]), 8'hE);
            checkOutput("press2_addr", 8'(pulse_addrs[1]), 8'hE);
            checkOutput("press3_addr", 8'(pulse_addrs[2]), 8'hE);
`endif
        end
`ifdef MAR_AUTO_INCREMENT_EN
        checkOutput("ptr_wrapped", 8'(address), 8'h1);
`else
        checkOutput("addr_static", 8'(address), 8'hE);
`endif

        // Press aborted by a one-cycle drop of manual mode while still held
        pulse_count = 0;
        applyStimulus(1'b1, 3);
        manual_mode = 1'b0;
        applyStimulus(1'b1, 1);
        manual_mode = 1'b1;
        applyStimulus(1'b1, 15);
        checkOutput("abort_no_pulse", 8'(pulse_count), 8'd0);
        applyStimulus(1'b0, 6);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 10);
        checkOutput("repress_pulse", 8'(pulse_count), 8'd1);

        // Asynchronous reset mid-HELD with mar=9
        manual_mode = 1'b0;
        bus = 8'h09;
        read_from_bus = 1'b1;
        tick();
        read_from_bus = 1'b0;
        checkOutput("load_09", 8'(address), 8'h9);
        manual_mode = 1'b1;
        applyStimulus(1'b0, 2);
        pulse_count = 0;
        applyStimulus(1'b1, 8);
        checkOutput("pre_reset_pulse", 8'(pulse_count), 8'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_manual_read", 8'(manual_read), 8'h0);
        manual_mode = 1'b0;
        #1;
        checkOutput("async_rst_address", 8'(address), 8'h0);
        write_button = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("rst_hold_read", 8'(manual_read), 8'h0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_mar", 8'(address), 8'h0);
        manual_mode = 1'b1;
        pulse_count = 0;
        applyStimulus(1'b0, 15);
        checkOutput("post_rst_no_pulse", 8'(pulse_count), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
